cadence_meter: RTL and testbench

- Parametrised successor to the free-running steps-per-minute calculator.
- Converts a free-running cumulative step counter into a rolling-window cadence in steps/min.
- Samples the counter once per second and keeps the per-second deltas in a ring buffer of WINDOW_SEC entries.
- Divides the windowed sum by the number of filled seconds using a multi-cycle sequential divider.
- Sits between the pedometer step counter and the display/UART formatting logic.

---
 rtl/cadence_meter.sv | 179 +++++++++++++++++
 tb/tb_cadence_meter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cadence_meter.sv
// Rolling-window cadence meter: per-second step deltas in a ring buffer, windowed sum * 60 / filled.
// Optional CADENCE_PEAK_HOLD_EN adds a peak_spm output holding the largest spm since reset/clear.
module cadence_meter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int WINDOW_SEC = 8,
  parameter int CNT_W      = 16,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] step_count,
  output logic [OUT_W-1:0] spm,
  output logic             spm_valid,
  output logic             window_full,
  output logic             busy
`ifdef CADENCE_PEAK_HOLD_EN
  ,
  output logic [OUT_W-1:0] peak_spm
`endif
);

  localparam int WR_W  = $clog2(WINDOW_SEC);
  localparam int SUM_W = CNT_W + WR_W;
  localparam int DIV_W = SUM_W + 6;
  localparam int FIL_W = $clog2(WINDOW_SEC + 1);
  localparam int PS_W  = $clog2(CLK_HZ);
  localparam int IT_W  = $clog2(DIV_W);
  localparam int MW    = (DIV_W > OUT_W) ? DIV_W : OUT_W;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [FIL_W-1:0] FIL_MAX = FIL_W'(WINDOW_SEC);
  localparam logic [IT_W-1:0]  IT_LAST = IT_W'(DIV_W - 1);
  localparam logic [MW-1:0]    SPM_MAX = MW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [PS_W-1:0]     ps;
  logic                tick;
  logic                primed;
  logic [CNT_W-1:0]    baseline;
  logic [CNT_W-1:0]    delta;
  logic [CNT_W-1:0]    ring [WINDOW_SEC];
  logic [WR_W-1:0]     wr;
  logic [SUM_W-1:0]    sum;
  logic [FIL_W-1:0]    filled;
  logic [DIV_W-1:0]    quo, quo_nxt;
  logic [FIL_W-1:0]    rem, dsr;
  logic [FIL_W:0]      rem_sh, rem_dif;
  logic                ge;
  logic [IT_W-1:0]     it_cnt;
  logic                div_last;
  logic [MW-1:0]       q_ext;
  logic [OUT_W-1:0]    spm_sat;

  assign tick        = (ps == PS_LAST);
  assign delta       = step_count - baseline;
  assign window_full = (filled == FIL_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ps <= '0;
    else if (clear)      ps <= '0;
    else if (tick)       ps <= '0;
    else                 ps <= ps + 1'b1;
  end

  // Ring entries start at zero, so subtracting the evicted entry is harmless while filling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed   <= 1'b0;
      baseline <= '0;
      wr       <= '0;
      sum      <= '0;
      filled   <= '0;
      for (int i = 0; i < WINDOW_SEC; i++) ring[i] <= '0;
    end else if (clear) begin
      primed   <= 1'b0;
      baseline <= '0;
      wr       <= '0;
      sum      <= '0;
      filled   <= '0;
      for (int i = 0; i < WINDOW_SEC; i++) ring[i] <= '0;
    end else if (tick) begin
      baseline <= step_count;
      if (!primed) begin
        primed <= 1'b1;
      end else begin
        ring[wr] <= delta;
        sum      <= sum - SUM_W'(ring[wr]) + SUM_W'(delta);
        wr       <= wr + 1'b1;
        if (filled != FIL_MAX) filled <= filled + 1'b1;
      end
    end
  end

  // state  | meaning
  // S_IDLE | waiting for a tick that produced a new ring entry
  // S_LOAD | latch sum*60 and the filled count into the divider
  // S_ITER | restoring division, one quotient bit per cycle
  // S_DONE | new spm visible, spm_valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    spm_valid = 1'b0;
    case (state)
      S_IDLE: if (tick && primed) state_nxt = S_LOAD;
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (it_cnt == IT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        spm_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  assign rem_sh   = {rem, quo[DIV_W-1]};
  assign ge       = (rem_sh >= {1'b0, dsr});
  assign rem_dif  = rem_sh - {1'b0, dsr};
  assign quo_nxt  = {quo[DIV_W-2:0], ge};
  assign div_last = (state == S_ITER) && (it_cnt == IT_LAST);
  assign q_ext    = MW'(quo_nxt);
  assign spm_sat  = (q_ext > SPM_MAX) ? {OUT_W{1'b1}} : OUT_W'(q_ext);

  // spm is written on the final iteration so it is already valid during S_DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      it_cnt <= '0;
      spm    <= '0;
    end else if (clear) begin
      quo    <= '0;
      rem    <= '0;
      dsr    <= '0;
      it_cnt <= '0;
      spm    <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          quo    <= DIV_W'(sum) * DIV_W'(60);
          rem    <= '0;
          dsr    <= filled;
          it_cnt <= '0;
        end
        S_ITER: begin
          quo    <= quo_nxt;
          rem    <= ge ? rem_dif[FIL_W-1:0] : rem_sh[FIL_W-1:0];
          it_cnt <= it_cnt + 1'b1;
          if (div_last) spm <= spm_sat;
        end
        default: ;
      endcase
    end
  end

`ifdef CADENCE_PEAK_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 peak_spm <= '0;
    else if (clear)                           peak_spm <= '0;
    else if (div_last && spm_sat > peak_spm)  peak_spm <= spm_sat;
  end
`endif

endmodule

// File: tb/tb_cadence_meter.sv
// Bench for cadence_meter: vector table, hand sequences for reset/clear corners, and randomized
// traffic checked every cycle against a queue-based reference model.
module tb_cadence_meter;
  localparam int CLK_HZ     = 32;
  localparam int WINDOW_SEC = 4;
  localparam int CNT_W      = 16;
  localparam int OUT_W      = 16;
  localparam int SUM_W      = CNT_W + $clog2(WINDOW_SEC);
  localparam int DIV_W      = SUM_W + 6;
  localparam int LAT        = DIV_W + 2;
  localparam longint SPM_MAX = (longint'(1) << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] step_count = '0;
  logic [OUT_W-1:0] spm;
  logic             spm_valid;
  logic             window_full;
  logic             busy;
`ifdef CADENCE_PEAK_HOLD_EN
  logic [OUT_W-1:0] peak_spm;
`endif

  cadence_meter #(
    .CLK_HZ(CLK_HZ), .WINDOW_SEC(WINDOW_SEC), .CNT_W(CNT_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .step_count(step_count),
    .spm(spm),
    .spm_valid(spm_valid),
    .window_full(window_full),
    .busy(busy)
`ifdef CADENCE_PEAK_HOLD_EN
    ,
    .peak_spm(peak_spm)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: seconds counted from cycles, deltas kept in a queue of at most WINDOW_SEC.
  int               m_ps = 0;
  bit               m_primed = 1'b0;
  logic [CNT_W-1:0] m_base = '0;
  logic [CNT_W-1:0] m_q[$];
  int               m_cd = 0;
  longint           m_pend = 0;
  longint           m_spm = 0;
  longint           m_peak = 0;
  int               tick_cnt = 0;

  initial begin : model
    logic             s_rst, s_clr, m_tick;
    logic [CNT_W-1:0] s_sc, d;
    longint           s;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_clr = clear;
      s_sc  = step_count;
      #1;
      if (!s_rst || s_clr) begin
        m_ps = 0; m_primed = 1'b0; m_base = '0; m_q.delete();
        m_cd = 0; m_spm = 0; m_peak = 0;
      end else begin
        m_tick = (m_ps == CLK_HZ - 1);
        m_ps   = m_tick ? 0 : m_ps + 1;
        if (m_cd > 0) m_cd--;
        if (m_cd == 1) begin
          m_spm = m_pend;
          if (m_pend > m_peak) m_peak = m_pend;
        end
        if (m_tick) begin
          tick_cnt++;
          if (!m_primed) begin
            m_primed = 1'b1;
            m_base   = s_sc;
          end else begin
            d      = s_sc - m_base;
            m_base = s_sc;
            m_q.push_back(d);
            if (m_q.size() > WINDOW_SEC) void'(m_q.pop_front());
            s = 0;
            foreach (m_q[i]) s += longint'(m_q[i]);
            m_pend = (s * 60) / m_q.size();
            if (m_pend > SPM_MAX) m_pend = SPM_MAX;
            m_cd = LAT;
          end
        end
      end
      chk("mdl_spm_valid", longint'(spm_valid), (m_cd == 1) ? 1 : 0);
      chk("mdl_busy", longint'(busy), (m_cd >= 2) ? 1 : 0);
      chk("mdl_spm", longint'(spm), m_spm);
      chk("mdl_window_full", longint'(window_full), (m_q.size() == WINDOW_SEC) ? 1 : 0);
`ifdef CADENCE_PEAK_HOLD_EN
      chk("mdl_peak_spm", longint'(peak_spm), m_peak);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    #1;
    chk("rst_spm", longint'(spm), 0);
    chk("rst_spm_valid", longint'(spm_valid), 0);
    chk("rst_window_full", longint'(window_full), 0);
    chk("rst_busy", longint'(busy), 0);
`ifdef CADENCE_PEAK_HOLD_EN
    chk("rst_peak_spm", longint'(peak_spm), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Returns at the falling edge just after the next one-second tick.
  task automatic wait_tick();
    int n0;
    n0 = tick_cnt;
    for (int k = 0; k < 2 * CLK_HZ + 2; k++) begin
      @(negedge clk);
      if (tick_cnt != n0) break;
    end
    if (tick_cnt == n0) begin
      checks++;
      failures++;
      $display("FAIL wait_tick at %0t: no tick within %0d cycles", $time, 2 * CLK_HZ + 2);
    end
  endtask

  // Called right after wait_tick; the pulse is due LAT-1 falling edges later.
  task automatic wait_pulse(input string name, input bit ev, input longint espm);
    int got;
    got = -1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (spm_valid) begin
        got = k;
        break;
      end
    end
    chk({name, "_pulse_at"}, got, ev ? LAT - 1 : -1);
    chk({name, "_spm"}, longint'(spm), espm);
  endtask

  typedef struct {
    bit               rst_first;
    logic [CNT_W-1:0] sc;
    bit               ev;
    logic [OUT_W-1:0] espm;
    bit               efull;
  } vec_t;

  vec_t tbl[16];

  initial begin : main
    logic [CNT_W-1:0] cur, inc;
    int               n, r;
    bit               found;

    tbl[0]  = '{1'b1, 16'd0,      1'b0, 16'd0,      1'b0};
    tbl[1]  = '{1'b0, 16'd2,      1'b1, 16'd120,    1'b0};
    tbl[2]  = '{1'b0, 16'd4,      1'b1, 16'd120,    1'b0};
    tbl[3]  = '{1'b0, 16'd6,      1'b1, 16'd120,    1'b0};
    tbl[4]  = '{1'b0, 16'd8,      1'b1, 16'd120,    1'b1};
    tbl[5]  = '{1'b0, 16'd10,     1'b1, 16'd120,    1'b1};
    tbl[6]  = '{1'b1, 16'd100,    1'b0, 16'd0,      1'b0};
    tbl[7]  = '{1'b0, 16'd101,    1'b1, 16'd60,     1'b0};
    tbl[8]  = '{1'b0, 16'd103,    1'b1, 16'd90,     1'b0};
    tbl[9]  = '{1'b0, 16'd106,    1'b1, 16'd120,    1'b0};
    tbl[10] = '{1'b0, 16'd110,    1'b1, 16'd150,    1'b1};
    tbl[11] = '{1'b0, 16'd115,    1'b1, 16'd210,    1'b1};
    tbl[12] = '{1'b1, 16'hFFFE,   1'b0, 16'd0,      1'b0};
    tbl[13] = '{1'b0, 16'h0003,   1'b1, 16'd300,    1'b0};
    tbl[14] = '{1'b1, 16'd0,      1'b0, 16'd0,      1'b0};
    tbl[15] = '{1'b0, 16'hFFFF,   1'b1, 16'hFFFF,   1'b0};

    rst = 1'b1;
    #2 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst_first) do_reset();
      @(negedge clk);
      step_count = tbl[i].sc;
      wait_tick();
      wait_pulse($sformatf("vec%0d", i), tbl[i].ev, longint'(tbl[i].espm));
      chk($sformatf("vec%0d_window_full", i), longint'(window_full), longint'(tbl[i].efull));
    end

    // Reset 10 cycles into a division: abandoned, and the next tick only re-captures the baseline.
    do_reset();
    @(negedge clk) step_count = 16'd0;
    wait_tick();
    @(negedge clk) step_count = 16'd2;
    wait_tick();
    wait_pulse("rstmid_pre", 1'b1, 120);
    @(negedge clk) step_count = 16'd9;
    wait_tick();
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_spm", longint'(spm), 0);
    chk("rstmid_busy", longint'(busy), 0);
    chk("rstmid_valid", longint'(spm_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (LAT) begin
      @(negedge clk);
      if (spm_valid) n++;
    end
    chk("rstmid_no_pulse", n, 0);
    @(negedge clk) step_count = 16'd50;
    wait_tick();
    wait_pulse("rstmid_baseline", 1'b0, 0);
    @(negedge clk) step_count = 16'd53;
    wait_tick();
    wait_pulse("rstmid_after", 1'b1, 180);

    // clear coincident with a tick after the window has filled.
    do_reset();
    @(negedge clk) step_count = 16'd0;
    wait_tick();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk) step_count = CNT_W'(5 * j);
      wait_tick();
      wait_pulse($sformatf("clr_fill%0d", j), 1'b1, 300);
    end
    chk("clr_full_before", longint'(window_full), 1);
    @(negedge clk) step_count = 16'd1000;
    found = 1'b0;
    for (int k = 0; k < 2 * CLK_HZ; k++) begin
      if (m_ps == CLK_HZ - 1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("clr_found_tick_cycle", longint'(found), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_window_full", longint'(window_full), 0);
    chk("clr_spm", longint'(spm), 0);
    chk("clr_busy", longint'(busy), 0);
`ifdef CADENCE_PEAK_HOLD_EN
    chk("clr_peak_spm", longint'(peak_spm), 0);
`endif
    @(negedge clk) step_count = 16'd1004;
    wait_tick();
    wait_pulse("clr_baseline", 1'b0, 0);
    @(negedge clk) step_count = 16'd1010;
    wait_tick();
    wait_pulse("clr_after", 1'b1, 360);

    // Random traffic: off-tick glitches on step_count, occasional big jumps and clears.
    do_reset();
    cur = CNT_W'($urandom);
    @(negedge clk) step_count = cur;
    wait_tick();
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) inc = CNT_W'($urandom);
      else        inc = CNT_W'($urandom_range(0, 250));
      cur = cur + inc;
      n = int'($urandom_range(1, 20));
      repeat (n) begin
        @(negedge clk);
        step_count = CNT_W'($urandom);
        clear = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
      clear = 1'b0;
      step_count = cur;
      wait_tick();
    end
    repeat (LAT + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
